// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine (rotation/vectoring), one micro-rotation per clock, internal atan table.
// Optional output gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_core #(
   parameter int Width      = 16,
   parameter int Iterations = 16,
   parameter int FracBits   = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic signed [Width-1:0] x_i,
   input  logic signed [Width-1:0] y_i,
   input  logic signed [Width-1:0] z_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic signed [Width+1:0] x_o,
   output logic signed [Width+1:0] y_o,
   output logic signed [Width-1:0] z_o
);
   // state | meaning
   // IDLE  | waiting for start_i, outputs hold last result
   // RUN   | one micro-rotation per clock, iter_q = current index
   // SCALE | (gain comp only) multiply by 1/K, then publish result
   localparam int XW = Width + 2;
   localparam int IW = (Iterations > 1) ? $clog2(Iterations) : 1;
   localparam int SH = (FracBits < 24) ? (24 - FracBits) : 0;
   localparam logic [63:0] RND = (SH > 0) ? (64'd1 << (SH - 1)) : 64'd0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
   localparam logic [1:0] S_SCALE = 2'd2;
   localparam int PW = XW + Width + 1;
   localparam logic signed [PW-1:0] KC    = PW'(int'(0.6072529350 * (2.0 ** (Width - 1))));
   localparam logic signed [PW-1:0] RND_K = PW'(1) <<< (Width - 2);
   logic signed [PW-1:0] x_prod, y_prod;
`endif

   // atan(2^-i) in degrees with 24 fractional bits
   function automatic logic [31:0] atan_raw(input logic [4:0] idx);
      case (idx)
         5'd0:  return 32'd754974720;
         5'd1:  return 32'd445687602;
         5'd2:  return 32'd235489088;
         5'd3:  return 32'd119537938;
         5'd4:  return 32'd60000934;
         5'd5:  return 32'd30029717;
         5'd6:  return 32'd15018523;
         5'd7:  return 32'd7509720;
         5'd8:  return 32'd3754917;
         5'd9:  return 32'd1877466;
         5'd10: return 32'd938734;
         5'd11: return 32'd469367;
         5'd12: return 32'd234684;
         5'd13: return 32'd117342;
         5'd14: return 32'd58671;
         5'd15: return 32'd29335;
         5'd16: return 32'd14668;
         5'd17: return 32'd7334;
         5'd18: return 32'd3667;
         5'd19: return 32'd1833;
         5'd20: return 32'd917;
         5'd21: return 32'd458;
         5'd22: return 32'd229;
         5'd23: return 32'd115;
         5'd24: return 32'd57;
         5'd25: return 32'd29;
         5'd26: return 32'd14;
         5'd27: return 32'd7;
         5'd28: return 32'd4;
         5'd29: return 32'd2;
         5'd30: return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic signed [Width-1:0] atan_entry(input logic [4:0] idx);
      logic [63:0] t;
      t = {32'd0, atan_raw(idx)};
      t = (t + RND) >> SH;
      return t[Width-1:0];
   endfunction

   logic [1:0]              state_q, state_d;
   logic [IW-1:0]           iter_q, iter_d;
   logic                    mode_q, mode_d;
   logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
   logic signed [Width-1:0] z_q, z_d;
   logic signed [XW-1:0]    x_out_q, x_out_d, y_out_q, y_out_d;
   logic signed [Width-1:0] z_out_q, z_out_d;
   logic                    done_q, done_d;

   logic signed [XW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
   logic signed [Width-1:0] atan_v, z_nxt;
   logic                    dir_pos;

   always_comb begin
      x_sh    = x_q >>> iter_q;
      y_sh    = y_q >>> iter_q;
      atan_v  = atan_entry(5'(iter_q));
      dir_pos = mode_q ? y_q[XW-1] : ~z_q[Width-1];
      x_nxt   = dir_pos ? (x_q - y_sh) : (x_q + y_sh);
      y_nxt   = dir_pos ? (y_q + x_sh) : (y_q - x_sh);
      z_nxt   = dir_pos ? (z_q - atan_v) : (z_q + atan_v);
   end

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      z_out_d = z_out_q;
      done_d  = 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
      x_prod  = PW'(x_q) * KC + RND_K;
      y_prod  = PW'(y_q) * KC + RND_K;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               iter_d  = '0;
               mode_d  = mode_i;
               x_d     = XW'(x_i);
               y_d     = XW'(y_i);
               z_d     = z_i;
            end
         end
         S_RUN: begin
            x_d    = x_nxt;
            y_d    = y_nxt;
            z_d    = z_nxt;
            iter_d = iter_q + 1'b1;
            if (iter_q == IW'(Iterations - 1)) begin
               iter_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
               state_d = S_SCALE;
`else
               state_d = S_IDLE;
               x_out_d = x_nxt;
               y_out_d = y_nxt;
               z_out_d = z_nxt;
               done_d  = 1'b1;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         S_SCALE: begin
            state_d = S_IDLE;
            x_out_d = XW'(x_prod >>> (Width - 1));
            y_out_d = XW'(y_prod >>> (Width - 1));
            z_out_d = z_q;
            done_d  = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         mode_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         z_out_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         z_out_q <= z_out_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = done_q;
   assign x_o    = x_out_q;
   assign y_o    = y_out_q;
   assign z_o    = z_out_q;
endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core: directed spec vectors plus randomized ops against
// a real-math-seeded reference model; honours CORDIC_GAIN_COMP_EN for latency and scaling.
module tb_cordic_iter_core;
   localparam int W   = 16;
   localparam int IT  = 16;
   localparam int FB  = 8;
   localparam int XW  = W + 2;
`ifdef CORDIC_GAIN_COMP_EN
   localparam bit GAIN = 1'b1;
`else
   localparam bit GAIN = 1'b0;
`endif
   localparam int LAT = IT + (GAIN ? 1 : 0);

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                start_i = 1'b0;
   logic                mode_i = 1'b0;
   logic signed [W-1:0] x_i = '0, y_i = '0, z_i = '0;
   logic                busy_o, done_o;
   logic signed [XW-1:0] x_o, y_o;
   logic signed [W-1:0] z_o;

   int pass_cnt = 0;
   int total = 0;
   longint atan_tab [32];

   cordic_iter_core #(.Width(W), .Iterations(IT), .FracBits(FB)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
      .x_i(x_i), .y_i(y_i), .z_i(z_i),
      .busy_o(busy_o), .done_o(done_o), .x_o(x_o), .y_o(y_o), .z_o(z_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic longint wrapn(input longint v, input int n);
      longint m;
      m = longint'(1) << n;
      v = v & (m - 1);
      if (v >= m / 2) v = v - m;
      return v;
   endfunction

   function automatic void build_table();
      real deg;
      longint t;
      for (int i = 0; i < 32; i++) begin
         deg = $atan(2.0 ** (-i)) * 180.0 / 3.14159265358979323846;
         t = longint'(deg * (2.0 ** 24));
         if (FB < 24) t = (t + (longint'(1) << (23 - FB))) >> (24 - FB);
         atan_tab[i] = wrapn(t, W);
      end
   endfunction

   // Plain integer evaluation of the micro-rotation recurrence
   function automatic void model(input bit md, input int xi, input int yi, input int zi,
                                 output int xo, output int yo, output int zo);
      longint x, y, z, xn, yn;
      bit pos;
      x = xi; y = yi; z = zi;
      for (int i = 0; i < IT; i++) begin
         pos = md ? (y < 0) : (z >= 0);
         if (pos) begin
            xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
         end else begin
            xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
         end
         x = wrapn(xn, XW); y = wrapn(yn, XW); z = wrapn(z, W);
      end
      if (GAIN) begin
         longint kc;
         kc = longint'(0.6072529350 * (2.0 ** (W - 1)));
         x = wrapn((x * kc + (longint'(1) << (W - 2))) >>> (W - 1), XW);
         y = wrapn((y * kc + (longint'(1) << (W - 2))) >>> (W - 1), XW);
      end
      xo = int'(x); yo = int'(y); zo = int'(z);
   endfunction

   task automatic start_op(input bit md, input int xv, input int yv, input int zv);
      mode_i = md; x_i = W'(xv); y_i = W'(yv); z_i = W'(zv);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk_i); #1;
         cyc++;
      end while (!done_o && cyc < 200);
      if (!done_o) $display("FAIL wait_done: timeout after %0d cycles, done_o never rose", cyc);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_flags: busy/done=%b required 00", {busy_o, done_o}); else pass_cnt++;
      total++; if ({x_o, y_o, z_o} !== '0) $display("FAIL reset_outputs: x=%0d y=%0d z=%0d required 0", x_o, y_o, z_o); else pass_cnt++;
      rst_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      total++; if ({busy_o, done_o, x_o, y_o, z_o} !== '0) $display("FAIL reset_idle: busy=%b done=%b x=%0d required all 0", busy_o, done_o, x_o); else pass_cnt++;
   endtask

   task automatic test_rotation();
      int cyc, ex, ey, ez, dx, dy, dz, tx, ty;
      model(1'b0, 10000, 0, 7680, ex, ey, ez);
      tx = GAIN ? 8660 : 14261;
      ty = GAIN ? 5000 : 8234;
      start_op(1'b0, 10000, 0, 7680);
      total++; if (busy_o !== 1'b1) $display("FAIL rot_busy: busy_o=%b required 1", busy_o); else pass_cnt++;
      wait_done(cyc);
      total++; if (cyc != LAT) $display("FAIL rot_latency: got %0d required %0d", cyc, LAT); else pass_cnt++;
      dx = int'(x_o) - tx; dy = int'(y_o) - ty; dz = int'(z_o);
      total++; if ((dx < 0 ? -dx : dx) > 4 || (dy < 0 ? -dy : dy) > 4 || (dz < 0 ? -dz : dz) > 2)
         $display("FAIL rot_tolerance: x=%0d y=%0d z=%0d required %0d/%0d/0 within 4/4/2", x_o, y_o, z_o, tx, ty);
      else pass_cnt++;
      total++; if (int'(x_o) != ex || int'(y_o) != ey || int'(z_o) != ez)
         $display("FAIL rot_exact: x=%0d y=%0d z=%0d required %0d %0d %0d", x_o, y_o, z_o, ex, ey, ez);
      else pass_cnt++;
      @(posedge clk_i); #1;
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rot_done_pulse: done=%b busy=%b required 0 0", done_o, busy_o); else pass_cnt++;
   endtask

   task automatic test_vectoring();
      int cyc, ex, ey, ez, dx, dy, dz, tx;
      model(1'b1, 10000, 10000, 0, ex, ey, ez);
      tx = GAIN ? 14142 : 23289;
      start_op(1'b1, 10000, 10000, 0);
      wait_done(cyc);
      total++; if (cyc != LAT) $display("FAIL vec_latency: got %0d required %0d", cyc, LAT); else pass_cnt++;
      dx = int'(x_o) - tx; dy = int'(y_o); dz = int'(z_o) - 11520;
      total++; if ((dx < 0 ? -dx : dx) > 4 || (dy < 0 ? -dy : dy) > 2 || (dz < 0 ? -dz : dz) > 3)
         $display("FAIL vec_tolerance: x=%0d y=%0d z=%0d required %0d/0/11520", x_o, y_o, z_o, tx);
      else pass_cnt++;
      total++; if (int'(x_o) != ex || int'(y_o) != ey || int'(z_o) != ez)
         $display("FAIL vec_exact: x=%0d y=%0d z=%0d required %0d %0d %0d", x_o, y_o, z_o, ex, ey, ez);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      int cyc, ex, ey, ez;
      model(1'b0, 10000, 0, 7680, ex, ey, ez);
      start_op(1'b0, 10000, 0, 7680);
      cyc = 0;
      do begin
         @(posedge clk_i); #1;
         cyc++;
         if (cyc == 5) begin
            start_i = 1'b1; mode_i = 1'b1; x_i = -16'sd1234; y_i = 16'sd777; z_i = 16'sd99;
         end else start_i = 1'b0;
      end while (!done_o && cyc < 200);
      start_i = 1'b0;
      total++; if (cyc != LAT) $display("FAIL ignore_latency: got %0d required %0d", cyc, LAT); else pass_cnt++;
      total++; if (int'(x_o) != ex || int'(y_o) != ey || int'(z_o) != ez)
         $display("FAIL ignore_result: x=%0d y=%0d z=%0d required %0d %0d %0d", x_o, y_o, z_o, ex, ey, ez);
      else pass_cnt++;
      @(posedge clk_i); #1;
      total++; if (busy_o !== 1'b0) $display("FAIL ignore_no_queue: busy_o=%b required 0", busy_o); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int cyc, ax, ay, az, bx, by, bz;
      model(1'b0, 5000, -3000, -5000, ax, ay, az);
      model(1'b1, 8000, -6000, 1000, bx, by, bz);
      start_op(1'b0, 5000, -3000, -5000);
      wait_done(cyc);
      total++; if (int'(x_o) != ax || int'(y_o) != ay || int'(z_o) != az)
         $display("FAIL b2b_first: x=%0d y=%0d z=%0d required %0d %0d %0d", x_o, y_o, z_o, ax, ay, az);
      else pass_cnt++;
      start_op(1'b1, 8000, -6000, 1000);
      total++; if (done_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL b2b_accept: done=%b busy=%b required 0 1", done_o, busy_o); else pass_cnt++;
      total++; if (int'(x_o) != ax || int'(z_o) != az) $display("FAIL b2b_hold: x=%0d z=%0d required %0d %0d", x_o, z_o, ax, az); else pass_cnt++;
      wait_done(cyc);
      total++; if (cyc != LAT) $display("FAIL b2b_latency: got %0d required %0d", cyc, LAT); else pass_cnt++;
      total++; if (int'(x_o) != bx || int'(y_o) != by || int'(z_o) != bz)
         $display("FAIL b2b_second: x=%0d y=%0d z=%0d required %0d %0d %0d", x_o, y_o, z_o, bx, by, bz);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      int cyc, ex, ey, ez, seen;
      start_op(1'b0, 12000, 3000, -9000);
      repeat (7) begin @(posedge clk_i); #1; end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      total++; if ({busy_o, done_o} !== 2'b00) $display("FAIL midrst_flags: busy/done=%b required 00", {busy_o, done_o}); else pass_cnt++;
      total++; if ({x_o, y_o, z_o} !== '0) $display("FAIL midrst_outputs: x=%0d y=%0d z=%0d required 0", x_o, y_o, z_o); else pass_cnt++;
      rst_i = 1'b0;
      seen = 0;
      repeat (LAT + 4) begin @(posedge clk_i); #1; if (done_o) seen++; end
      total++; if (seen != 0) $display("FAIL midrst_no_done: done pulses=%0d required 0", seen); else pass_cnt++;
      model(1'b1, 9000, 4000, 0, ex, ey, ez);
      start_op(1'b1, 9000, 4000, 0);
      wait_done(cyc);
      total++; if (cyc != LAT || int'(x_o) != ex || int'(y_o) != ey || int'(z_o) != ez)
         $display("FAIL midrst_recover: lat=%0d x=%0d y=%0d z=%0d required %0d %0d %0d %0d", cyc, x_o, y_o, z_o, LAT, ex, ey, ez);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int cyc, ex, ey, ez, xv, yv, zv;
      bit md;
      for (int n = 0; n < 30; n++) begin
         md = 1'($urandom_range(0, 1));
         xv = int'($signed(16'($urandom)));
         yv = int'($signed(16'($urandom)));
         zv = int'($signed(16'($urandom)));
         model(md, xv, yv, zv, ex, ey, ez);
         start_op(md, xv, yv, zv);
         mode_i = ~md;
         wait_done(cyc);
         total++; if (cyc != LAT || int'(x_o) != ex || int'(y_o) != ey || int'(z_o) != ez)
            $display("FAIL random_%0d: mode=%0d in=%0d,%0d,%0d lat=%0d out=%0d,%0d,%0d required %0d,%0d,%0d",
                     n, md, xv, yv, zv, cyc, x_o, y_o, z_o, ex, ey, ez);
         else pass_cnt++;
      end
   endtask

   initial begin
      build_table();
      #1;
      test_reset();
      test_rotation();
      test_vectoring();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
